// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with KMP-style prefix tracking.
// The next-state table is computed from PATTERN at elaboration, so no
// pattern register exists at runtime.
//
// state (p)      | meaning
// ---------------+--------------------------------------------------
// 0              | no prefix of PATTERN matched
// k (1..N-1)     | the last k consumed bits equal the first k pattern bits
module seq_detector_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     i,
  output logic                     out,
  output logic [CNT_W-1:0]         match_count,
  output logic [$clog2(N+1)-1:0]   progress
);

  localparam int PW  = $clog2(N+1);
  localparam int TBL = 2**PW;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detector_param: N must be within 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be at least 1");
  end

  // Longest pattern prefix that is a suffix of (first p pattern bits, then b).
  // A result of N means the pattern completed.
  function automatic int calc_next(input int p, input int b);
    int pv;
    int seq;
    int lim;
    int res;
    pv  = int'(PATTERN);
    res = 0;
    if (p < N) begin
      seq = ((pv >> (N - p)) << 1) | b;
      lim = (p + 1 < N) ? p + 1 : N;
      for (int l = 1; l <= lim; l++) begin
        if ((seq & ((1 << l) - 1)) == (pv >> (N - l))) res = l;
      end
    end
    return res;
  endfunction

  // Longest proper prefix of PATTERN that is also its suffix.
  function automatic int calc_fail_n();
    int pv;
    int res;
    pv  = int'(PATTERN);
    res = 0;
    for (int l = 1; l < N; l++) begin
      if ((pv & ((1 << l) - 1)) == (pv >> (N - l))) res = l;
    end
    return res;
  endfunction

  localparam logic [PW-1:0] L_N     = PW'(N);
  localparam logic [PW-1:0] L_AFTER = OVERLAP ? PW'(calc_fail_n()) : '0;

  // Transition table sized to a power of two so any PW-bit state indexes it;
  // unreachable rows resolve to 0.
  logic [PW-1:0] w_nxt_tbl [TBL][2];

  for (genvar gp = 0; gp < TBL; gp++) begin : g_row
    for (genvar gb = 0; gb < 2; gb++) begin : g_col
      localparam int NL = calc_next(gp, gb);
      assign w_nxt_tbl[gp][gb] = PW'(NL);
    end
  end

  logic [PW-1:0]    r_p;
  logic             r_out;
  logic [CNT_W-1:0] r_cnt;

  logic [PW-1:0]    w_p_nxt;
  logic             w_out_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PW-1:0]    w_len;

  // State, pulse and counter registers; reset forces everything to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p   <= '0;
      r_out <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_p   <= w_p_nxt;
      r_out <= w_out_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Next state: clear wins over enable; a completed pattern pulses out,
  // bumps the saturating counter and restarts from the overlap point or zero.
  always_comb begin
    w_p_nxt   = r_p;
    w_out_nxt = 1'b0;
    w_cnt_nxt = r_cnt;
    w_len     = w_nxt_tbl[r_p][i];
    if (clr) begin
      w_p_nxt   = '0;
      w_cnt_nxt = '0;
    end else if (en) begin
      if (w_len == L_N) begin
        w_out_nxt = 1'b1;
        w_p_nxt   = L_AFTER;
        if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
        w_p_nxt = w_len;
      end
    end
  end

  assign out         = r_out;
  assign match_count = r_cnt;
  assign progress    = r_p;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic en;
  logic din;

  always #5 clk = ~clk;

  logic       o0, o1, o2, o3, o4;
  logic [7:0] c0, c1, c3;
  logic [1:0] c2;
  logic [3:0] c4;
  logic [2:0] p0, p1, p2, p4;
  logic [1:0] p3;

  seq_detector_param dut0 (
    .clock(clk), .reset(rst_n), .clr(clr), .en(en), .i(din),
    .out(o0), .match_count(c0), .progress(p0));

  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clock(clk), .reset(rst_n), .clr(clr), .en(en), .i(din),
    .out(o1), .match_count(c1), .progress(p1));

  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .clock(clk), .reset(rst_n), .clr(clr), .en(en), .i(din),
    .out(o2), .match_count(c2), .progress(p2));

  seq_detector_param #(.N(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(8)) dut3 (
    .clock(clk), .reset(rst_n), .clr(clr), .en(en), .i(din),
    .out(o3), .match_count(c3), .progress(p3));

  seq_detector_param #(.N(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .CNT_W(4)) dut4 (
    .clock(clk), .reset(rst_n), .clr(clr), .en(en), .i(din),
    .out(o4), .match_count(c4), .progress(p4));

  // Reference: bit history of consumed bits per instance.
  int m_n   [5] = '{4, 4, 4, 3, 5};
  int m_pat [5] = '{11, 11, 11, 7, 18};
  int m_ov  [5] = '{1, 0, 1, 1, 1};
  int m_max [5] = '{255, 255, 3, 255, 15};
  int h_val [5];
  int h_len [5];
  int e_cnt [5];
  int e_out [5];
  int pulses[5];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_prog(input int k);
    int best = 0;
    for (int l = 1; l < m_n[k]; l++) begin
      if (l <= h_len[k] &&
          (h_val[k] & ((1 << l) - 1)) == (m_pat[k] >> (m_n[k] - l)))
        best = l;
    end
    return best;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      h_val[k] = 0; h_len[k] = 0; e_cnt[k] = 0; e_out[k] = 0;
    end
  endtask

  task automatic model_edge(input bit c, input bit e, input bit b);
    for (int k = 0; k < 5; k++) begin
      e_out[k] = 0;
      if (c) begin
        h_val[k] = 0; h_len[k] = 0; e_cnt[k] = 0;
      end else if (e) begin
        h_val[k] = ((h_val[k] << 1) | int'(b)) & 16'hFFFF;
        h_len[k] = (h_len[k] < 16) ? h_len[k] + 1 : 16;
        if (h_len[k] >= m_n[k] &&
            (h_val[k] & ((1 << m_n[k]) - 1)) == m_pat[k]) begin
          e_out[k] = 1;
          if (e_cnt[k] < m_max[k]) e_cnt[k]++;
          if (m_ov[k] == 0) begin
            h_val[k] = 0; h_len[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    int ob_o[5];
    int ob_c[5];
    int ob_p[5];
    ob_o = '{int'(o0), int'(o1), int'(o2), int'(o3), int'(o4)};
    ob_c = '{int'(c0), int'(c1), int'(c2), int'(c3), int'(c4)};
    ob_p = '{int'(p0), int'(p1), int'(p2), int'(p3), int'(p4)};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_out%0d", tag, k), ob_o[k], e_out[k]);
      chk($sformatf("%s_cnt%0d", tag, k), ob_c[k], e_cnt[k]);
      chk($sformatf("%s_prog%0d", tag, k), ob_p[k], model_prog(k));
      if (ob_o[k] != 0) pulses[k]++;
    end
  endtask

  task automatic step(input bit c, input bit e, input bit b);
    clr = c; en = e; din = b;
    @(posedge clk);
    model_edge(c, e, b);
    #1;
    compare_all("step");
  endtask

  // Called #1 after a rising edge: checks the asynchronous effect, then holds.
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    compare_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    compare_all("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic clear_pulses();
    for (int k = 0; k < 5; k++) pulses[k] = 0;
  endtask

  initial begin
    int sb[4];
    int exp_p[4];
    sb    = '{1, 0, 1, 1};
    exp_p = '{1, 2, 3, 1};
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; din = 1'b0;
    model_clear();
    clear_pulses();

    #2;
    compare_all("rst0");
    repeat (3) @(posedge clk);
    #1;
    compare_all("rst1");
    chk("rst_out", int'(o0), 0);
    chk("rst_cnt", int'(c0), 0);
    chk("rst_prog", int'(p0), 0);
    rst_n = 1'b1;

    // single match
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 1'b1, sb[n][0]);
      chk($sformatf("single_prog_b%0d", n + 1), int'(p0), exp_p[n]);
    end
    chk("single_out", int'(o0), 1);
    chk("single_cnt", int'(c0), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("single_fall", int'(o0), 0);

    // overlap vs non-overlap
    step(1'b1, 1'b0, 1'b0);
    chk("clr_cnt", int'(c0), 0);
    clear_pulses();
    begin
      int ov[7];
      ov = '{1, 0, 1, 1, 0, 1, 1};
      for (int n = 0; n < 7; n++) step(1'b0, 1'b1, ov[n][0]);
    end
    chk("ovl_pulses_ov1", pulses[0], 2);
    chk("ovl_pulses_ov0", pulses[1], 1);
    chk("ovl_cnt_ov1", int'(c0), 2);
    chk("ovl_cnt_ov0", int'(c1), 1);

    // gapped enable
    step(1'b1, 1'b0, 1'b0);
    clear_pulses();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("gap_hold", int'(p0), 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("gap_pulse", pulses[0], 1);
    chk("gap_out", int'(o0), 1);

    // saturation of the 2-bit counter
    step(1'b1, 1'b0, 1'b0);
    clear_pulses();
    for (int m = 0; m < 5; m++)
      for (int n = 0; n < 4; n++) step(1'b0, 1'b1, sb[n][0]);
    chk("sat_cnt", int'(c2), 3);
    chk("sat_pulses", pulses[2], 5);
    chk("sat_wide_cnt", int'(c0), 5);

    // back-to-back matches on all-ones pattern
    step(1'b1, 1'b0, 1'b0);
    clear_pulses();
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 1'b1, 1'b1);
      if (n >= 2) chk($sformatf("b2b_out_b%0d", n + 1), int'(o3), 1);
    end
    chk("b2b_pulses", pulses[3], 3);

    // reset mid-sequence
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    apply_reset();
    chk("midrst_prog", int'(p0), 0);
    step(1'b0, 1'b1, 1'b1);
    chk("midrst_out", int'(o0), 0);
    chk("midrst_prog1", int'(p0), 1);

    // clear with enable on the same edge
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1, sb[n][0]);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_en_prog", int'(p0), 0);
    chk("clr_en_cnt", int'(c0), 0);
    chk("clr_en_out", int'(o0), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) apply_reset();
      else step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.

Parameters (name, default, meaning):
REQ-002 The block SHALL provide `N`, default 4: pattern length in bits, legal range 2..16.
REQ-003 The block SHALL provide `PATTERN`, default 4'b1011: N-bit target; `PATTERN[N-1]` is the first bit in time.
REQ-004 The block SHALL provide `OVERLAP`, default 1: 1 = overlapping matches allowed; 0 = progress restarts from zero after a match.
REQ-005 The block SHALL provide `CNT_W`, default 8: width of the match counter.

Ports (name, direction, width, meaning):
REQ-006 `clock`, input, 1: rising-edge clock.
REQ-007 `reset`, input, 1: asynchronous active-low reset.
REQ-008 `clr`, input, 1: synchronous clear of progress and count.
REQ-009 `en`, input, 1: qualifies `i`; a bit is consumed only on an edge with en=1.
REQ-010 `i`, input, 1: serial data bit.
REQ-011 `out`, output, 1: registered match pulse.
REQ-012 `match_count`, output, CNT_W: saturating count of matches.
REQ-013 `progress`, output, $clog2(N+1): current matched-prefix length, 0..N-1.

Function
REQ-014 The detector SHALL be a state machine whose state is the matched-prefix length p, 0..N-1, held in a register and presented on `progress`.
REQ-015 On an edge with en=1 and clr=0, the next p SHALL be the longest prefix of PATTERN that is a suffix of (the current p-length prefix followed by `i`), KMP semantics.
- The failure function SHALL be computed at elaboration from PATTERN.
- No runtime pattern storage.
REQ-016 When the next prefix length reaches N, a match SHALL occur:
- out=1 on the following cycle;
- match_count increments;
- p becomes fail(N) if OVERLAP=1, else 0.
REQ-017 `out` SHALL be high for exactly one cycle per match, registered, with latency 1 edge from the sampling of the completing bit.
REQ-018 On an edge with en=0 and clr=0:
- p SHALL hold;
- out SHALL be 0;
- match_count SHALL hold.
REQ-019 clr=1 SHALL take priority over en.
- On that edge p becomes 0, match_count becomes 0 and out becomes 0.
- The bit on `i` is discarded.
REQ-020 match_count SHALL saturate at 2^CNT_W-1 and never wrap; out SHALL still pulse on matches while saturated.
REQ-021 Back-to-back matches SHALL be possible when OVERLAP=1 and fail(N)=N-1 (e.g. PATTERN all-ones); out then stays high on consecutive cycles.
REQ-022 Illegal parameter values (N<2, N>16) SHALL be rejected at elaboration.

Reset
REQ-023 While reset=0, irrespective of clock:
- p SHALL be 0;
- out SHALL be 0;
- match_count SHALL be 0.
REQ-024 Asserting reset mid-sequence SHALL discard all partial progress; the first edge after release with en=1 consumes a fresh first bit.
REQ-025 No output SHALL be X or undefined after reset, including under simulation.

Verification
Defaults unless stated: N=4, PATTERN=1011.
REQ-026 Reset: hold reset=0 and toggle clock -> out=0, match_count=0, progress=0.
REQ-027 Single match: en=1, stream 1,0,1,1.
- Expected progress after each edge: 1, 2, 3, then 1 after the match.
- Expected out=1 the cycle after the 4th bit; match_count=1.
REQ-028 Overlap: stream 1,0,1,1,0,1,1.
- OVERLAP=1 -> two out pulses, after bits 4 and 7; match_count=2.
- OVERLAP=0 -> one pulse, after bit 4; match_count=1.
REQ-029 Gapped enable: 1,(en=0 with i=1),0,1,1.
- Expected progress holds at 1 during the gap.
- Expected single pulse after the last enabled bit.
REQ-030 Saturation: CNT_W=2, feed five matches -> match_count=3, five out pulses.
REQ-031 Reset and clear mid-sequence:
- After 1,0,1, pulse reset=0, then feed 1 -> no pulse, progress=1.
- With clr=1 and en=1 on the same edge -> progress=0, match_count=0.
